// File: rtl/modpoly_reader.sv
// rtl/modpoly_reader.sv - streams a contiguous coefficient range out of an async-read RAM
// One coefficient per cycle on a valid/ready stream; wraps at the top of the address space.
module modpoly_reader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_address,
  input  logic [RAM_ADDR_BITS:0]   length,
  input  logic                     abort,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     read_data,
  output logic [RAM_WIDTH-1:0]     coef_data,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic                     coef_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = RAM_ADDR_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]         remaining_q, remaining_d;
  logic [RAM_WIDTH-1:0]     coef_data_q, coef_data_d;
  logic                     coef_valid_q, coef_valid_d;
  logic                     coef_last_q, coef_last_d;
  logic                     out_free;

  // coef_ready only gates the output-register enable, never an output directly
  assign out_free = !coef_valid_q || coef_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    coef_data_d  = coef_data_q;
    coef_valid_d = coef_valid_q;
    coef_last_d  = coef_last_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      coef_valid_d = 1'b0;
      coef_last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              ptr_d       = base_address;
              remaining_d = length;
              state_d     = S_STREAM;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_STREAM: begin
          if (out_free) begin
            coef_data_d  = read_data;
            coef_valid_d = 1'b1;
            coef_last_d  = (remaining_q == CNT_W'(1));
            ptr_d        = ptr_q + 1'b1;
            remaining_d  = remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (coef_valid_q && coef_ready) begin
            coef_valid_d = 1'b0;
            coef_last_d  = 1'b0;
            state_d      = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      coef_data_q  <= '0;
      coef_valid_q <= 1'b0;
      coef_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      coef_data_q  <= coef_data_d;
      coef_valid_q <= coef_valid_d;
      coef_last_q  <= coef_last_d;
    end
  end

  assign read_address = ptr_q;
  assign coef_data    = coef_data_q;
  assign coef_valid   = coef_valid_q;
  assign coef_last    = coef_last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_modpoly_reader.sv
// tb/tb_modpoly_reader.sv - self-checking bench for modpoly_reader
// Reference: expected stream is mem[(base+k) mod 2048], k = 0..len-1, last on k = len-1.
module tb_modpoly_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] base_address;
  logic [11:0] length;
  logic        abort;
  logic [10:0] read_address;
  logic [12:0] read_data;
  logic [12:0] coef_data;
  logic        coef_valid;
  logic        coef_ready;
  logic        coef_last;
  logic        busy;
  logic        done;

  logic [12:0] mem [2048];
  int checks   = 0;
  int failures = 0;

  assign read_data = mem[read_address];

  modpoly_reader #(.RAM_WIDTH(13), .RAM_ADDR_BITS(11)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_address (base_address),
    .length       (length),
    .abort        (abort),
    .read_address (read_address),
    .read_data    (read_data),
    .coef_data    (coef_data),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_last    (coef_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready held high, 1: random ready, 2: fixed pattern 1,0,0,1,0,1,1 from first valid cycle
  task automatic run_transfer(input int base, input int len, input int mode, input bit inject);
    int t, hs, first_t, done_t, limit;
    bit prev_stall;
    logic [12:0] prev_data;
    logic prev_last;
    bit pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    limit = len * 8 + 40;
    hs = 0;
    first_t = -1;
    done_t = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;

    @(negedge clk);
    start = 1'b1;
    base_address = 11'(base);
    length = 12'(len);
    coef_ready = 1'b1;
    @(negedge clk);
    t = 1;
    while (t <= limit && done_t < 0) begin
      if (mode == 0) coef_ready = 1'b1;
      else if (mode == 1) coef_ready = 1'($urandom_range(0, 1));
      else coef_ready = (t >= 2 && t - 2 < 7) ? pat[t-2] : 1'b1;
      if (inject && t == 3) begin
        start = 1'b1;
        base_address = 11'd0;
        length = 12'd7;
      end else begin
        start = 1'b0;
        base_address = 11'($urandom);
        length = 12'($urandom);
      end
      #1;
      chk("busy_during", busy, 1);
      if (t == 1 && len > 0) chk("first_addr", read_address, base);
      if (mode == 0 && t <= len) chk("rd_addr", read_address, (base + t - 1) % 2048);
      if (prev_stall) begin
        chk("stall_valid", coef_valid, 1);
        chk("stall_data", coef_data, prev_data);
        chk("stall_last", coef_last, prev_last);
      end
      if (coef_valid && first_t < 0) first_t = t;
      if (coef_valid && coef_ready) begin
        chk("data", coef_data, mem[(base + hs) % 2048]);
        chk("last", coef_last, (hs == len - 1));
        hs++;
      end
      if (done) done_t = t;
      prev_stall = coef_valid && !coef_ready;
      prev_data = coef_data;
      prev_last = coef_last;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    #1;
    chk("done_seen", (done_t >= 0), 1);
    chk("handshakes", hs, len);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", coef_valid, 0);
    if (mode == 0) begin
      chk("done_time", done_t, (len == 0) ? 1 : len + 2);
      chk("first_valid_time", first_t, (len == 0) ? -1 : 2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_address = '0;
    length = '0;
    abort = 1'b0;
    coef_ready = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 13'(i);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr", read_address, 0);
    chk("rst_data", coef_data, 0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_last", coef_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    run_transfer(10, 5, 0, 1'b0);
    run_transfer(2045, 6, 0, 1'b0);
    run_transfer(0, 4, 2, 1'b0);
    run_transfer(77, 0, 0, 1'b0);
    run_transfer(0, 2048, 0, 1'b0);
    run_transfer(500, 12, 0, 1'b1);

    for (int i = 0; i < 2048; i++) mem[i] = 13'($urandom);
    for (int k = 0; k < 8; k++) begin
      run_transfer(int'($urandom_range(0, 2047)), int'($urandom_range(1, 64)), 1, 1'b0);
    end

    // abort three cycles into a long transfer
    @(negedge clk);
    start = 1'b1;
    base_address = 11'd100;
    length = 12'd100;
    coef_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("pre_abort_valid", coef_valid, 1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_valid", coef_valid, 0);
    chk("abort_last", coef_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    run_transfer(300, 9, 1, 1'b0);

    // reset mid-stream, with start held during reset
    @(negedge clk);
    start = 1'b1;
    base_address = 11'd20;
    length = 12'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_valid", coef_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    base_address = 11'd40;
    length = 12'd3;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", coef_valid, 0);
    chk("mid_rst_last", coef_last, 0);
    chk("mid_rst_data", coef_data, 0);
    chk("mid_rst_addr", read_address, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    #1;
    chk("rst_start_ignored", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    run_transfer(1000, 16, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
